// File: rtl/cpu_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_seq
// Brief    : Multi-cycle CPU control sequencer (fetch, decode, step, RAM
//            timeout fault). Interrupt entry is built only when the macro
//            CPU_SEQ_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_seq #(
    parameter int IW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_cycle_n,
    input  logic [IW-1:0] instruction,
    input  logic          ram_ready,
    input  logic          irq,
    output logic [7:0]    state,
    output logic [3:0]    cycle,
    output logic [7:0]    opcode,
    output logic          halted,
    output logic          timeout_err,
    output logic          irq_ack
);

    localparam logic [7:0] c_S_FETCH_PC      = 8'h01;
    localparam logic [7:0] c_S_FETCH_INST    = 8'h02;
    localparam logic [7:0] c_S_HALT          = 8'h03;
    localparam logic [7:0] c_S_JUMP          = 8'h04;
    localparam logic [7:0] c_S_OUT           = 8'h05;
    localparam logic [7:0] c_S_ALU_EXEC      = 8'h07;
    localparam logic [7:0] c_S_MOV_FETCH     = 8'h09;
    localparam logic [7:0] c_S_MOV_LOAD      = 8'h0A;
    localparam logic [7:0] c_S_FETCH_SP      = 8'h0C;
    localparam logic [7:0] c_S_PC_STORE      = 8'h0D;
    localparam logic [7:0] c_S_TMP_JUMP      = 8'h0E;
    localparam logic [7:0] c_S_RET           = 8'h0F;
    localparam logic [7:0] c_S_INC_SP        = 8'h10;
    localparam logic [7:0] c_S_SET_ADDR      = 8'h11;
    localparam logic [7:0] c_S_IN            = 8'h12;
    localparam logic [7:0] c_S_REG_STORE     = 8'h13;
    localparam logic [7:0] c_S_SET_REG       = 8'h14;
    localparam logic [7:0] c_S_LOAD_IMM      = 8'h15;
    localparam logic [7:0] c_S_WAIT_RAM      = 8'h16;
    localparam logic [7:0] c_S_ALU_WRITEBACK = 8'h17;
    localparam logic [7:0] c_S_DECODE        = 8'h18;
    localparam logic [7:0] c_S_OPERAND       = 8'h19;
    localparam logic [7:0] c_S_IRQ_ENTRY     = 8'h1A;

    localparam logic [7:0] c_OP_NOP  = 8'h00;
    localparam logic [7:0] c_OP_CALL = 8'h01;
    localparam logic [7:0] c_OP_RET  = 8'h02;
    localparam logic [7:0] c_OP_OUT  = 8'h03;
    localparam logic [7:0] c_OP_IN   = 8'h04;
    localparam logic [7:0] c_OP_HLT  = 8'h05;
    localparam logic [7:0] c_OP_CMP  = 8'h06;
    localparam logic [7:0] c_OP_LDI  = 8'h10;
    localparam logic [7:0] c_OP_JMP  = 8'h18;
    localparam logic [7:0] c_OP_PUSH = 8'h20;
    localparam logic [7:0] c_OP_POP  = 8'h28;
    localparam logic [7:0] c_OP_ALU  = 8'h40;
    localparam logic [7:0] c_OP_MOV  = 8'h80;

    localparam logic [8:0] c_TIMEOUT = 9'(TIMEOUT);

    logic [7:0] r_state;
    logic [3:0] r_cycle;
    logic [7:0] r_opcode;
    logic [7:0] r_inst;
    logic [7:0] r_wait;
    logic       r_timeout_err;
    logic       r_irq_seq;

    logic [7:0] w_next;
    logic [7:0] w_wait_next;
    logic [8:0] w_wait_inc;
    logic       w_set_tout;
    logic [7:0] w_dec;
    logic [7:0] w_last;
    logic       w_irq_req;

`ifdef CPU_SEQ_IRQ_EN
    assign w_irq_req = irq;
    assign irq_ack   = (r_state == c_S_IRQ_ENTRY);
`else
    // irq is deliberately ignored in this build
    assign w_irq_req = 1'b0 & irq;
    assign irq_ack   = 1'b0;
`endif

    assign state       = r_state;
    assign cycle       = r_cycle;
    assign opcode      = r_opcode;
    assign halted      = (r_state == c_S_HALT);
    assign timeout_err = r_timeout_err;

    assign w_wait_inc = {1'b0, r_wait} + 9'd1;
    assign w_last     = w_irq_req ? c_S_IRQ_ENTRY : c_S_FETCH_PC;

    always_comb begin
        w_dec = c_OP_NOP;
        casez (r_inst)
            8'h00, 8'h01, 8'h02, 8'h03,
            8'h04, 8'h05, 8'h06:  w_dec = r_inst;
            8'b00_010_???:        w_dec = c_OP_LDI;
            8'b00_011_???:        w_dec = c_OP_JMP;
            8'b00_100_???:        w_dec = c_OP_PUSH;
            8'b00_101_???:        w_dec = c_OP_POP;
            8'b01_???_000:        w_dec = c_OP_ALU;
            8'b10_???_???:        w_dec = c_OP_MOV;
            default:              w_dec = c_OP_NOP;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_wait_next = 8'd0;
        w_set_tout  = 1'b0;
        case (r_state)
            c_S_FETCH_PC:   w_next = c_S_WAIT_RAM;
            c_S_WAIT_RAM,
            c_S_OPERAND: begin
                // Ready wins even on the cycle the counter would expire
                if (ram_ready) begin
                    if (r_state == c_S_WAIT_RAM) begin
                        w_next = c_S_FETCH_INST;
                    end else begin
                        case (r_opcode)
                            c_OP_JMP:          w_next = c_S_JUMP;
                            c_OP_LDI:          w_next = c_S_LOAD_IMM;
                            c_OP_OUT, c_OP_IN: w_next = c_S_SET_ADDR;
                            c_OP_CALL:         w_next = c_S_FETCH_SP;
                            default:           w_next = c_S_FETCH_PC;
                        endcase
                    end
                end else if (w_wait_inc >= c_TIMEOUT) begin
                    w_next     = c_S_HALT;
                    w_set_tout = 1'b1;
                end else begin
                    w_wait_next = w_wait_inc[7:0];
                end
            end
            c_S_FETCH_INST: w_next = c_S_DECODE;
            c_S_DECODE: begin
                case (w_dec)
                    c_OP_HLT:                      w_next = c_S_HALT;
                    c_OP_JMP, c_OP_LDI, c_OP_OUT,
                    c_OP_IN, c_OP_CALL:            w_next = c_S_OPERAND;
                    c_OP_MOV:                      w_next = c_S_MOV_FETCH;
                    c_OP_ALU, c_OP_CMP:            w_next = c_S_ALU_EXEC;
                    c_OP_PUSH:                     w_next = c_S_FETCH_SP;
                    c_OP_POP, c_OP_RET:            w_next = c_S_INC_SP;
                    default:                       w_next = w_last;
                endcase
            end
            c_S_HALT: begin
                if (w_irq_req && !r_timeout_err) begin
                    w_next = c_S_IRQ_ENTRY;
                end
            end
            c_S_MOV_FETCH:  w_next = c_S_MOV_LOAD;
            c_S_ALU_EXEC:   w_next = (r_opcode == c_OP_CMP) ? w_last : c_S_ALU_WRITEBACK;
            c_S_SET_ADDR:   w_next = (r_opcode == c_OP_IN) ? c_S_IN : c_S_OUT;
            c_S_INC_SP:     w_next = c_S_FETCH_SP;
            c_S_FETCH_SP: begin
                if (r_irq_seq) begin
                    w_next = c_S_PC_STORE;
                end else begin
                    case (r_opcode)
                        c_OP_PUSH: w_next = c_S_REG_STORE;
                        c_OP_POP:  w_next = c_S_SET_REG;
                        c_OP_RET:  w_next = c_S_RET;
                        c_OP_CALL: w_next = c_S_PC_STORE;
                        default:   w_next = c_S_FETCH_PC;
                    endcase
                end
            end
            c_S_PC_STORE:   w_next = c_S_TMP_JUMP;
            // An interrupt return always fetches one instruction before re-entry
            c_S_TMP_JUMP:   w_next = r_irq_seq ? c_S_FETCH_PC : w_last;
            c_S_IRQ_ENTRY:  w_next = c_S_FETCH_SP;
            c_S_JUMP, c_S_LOAD_IMM, c_S_MOV_LOAD, c_S_ALU_WRITEBACK,
            c_S_OUT, c_S_IN, c_S_REG_STORE, c_S_SET_REG,
            c_S_RET:        w_next = w_last;
            default:        w_next = c_S_FETCH_PC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_cycle_n) begin
            r_state       <= c_S_FETCH_PC;
            r_cycle       <= 4'd0;
            r_opcode      <= c_OP_NOP;
            r_inst        <= 8'd0;
            r_wait        <= 8'd0;
            r_timeout_err <= 1'b0;
            r_irq_seq     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (w_set_tout) begin
                r_timeout_err <= 1'b1;
            end
            if (r_state == c_S_FETCH_INST) begin
                r_inst <= instruction[IW-1 -: 8];
            end
            if (r_state == c_S_DECODE) begin
                r_opcode <= w_dec;
            end
            if (w_next == c_S_FETCH_PC || w_next == c_S_IRQ_ENTRY) begin
                r_cycle <= 4'd0;
            end else if (r_cycle != 4'hF) begin
                r_cycle <= r_cycle + 4'd1;
            end
            if (w_next == c_S_IRQ_ENTRY) begin
                r_irq_seq <= 1'b1;
            end else if (w_next == c_S_FETCH_PC) begin
                r_irq_seq <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_seq
// Brief    : Self-checking bench for cpu_seq: vector table, directed corner
//            sequences and randomized run against a step-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_seq;

    localparam int c_TO = 4;
`ifdef CPU_SEQ_IRQ_EN
    localparam bit c_IRQ_ON = 1'b1;
`else
    localparam bit c_IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_cycle_n = 1'b0;
    logic [7:0] instruction = 8'h00;
    logic       ram_ready = 1'b0;
    logic       irq = 1'b0;
    logic [7:0] state;
    logic [3:0] cycle;
    logic [7:0] opcode;
    logic       halted;
    logic       timeout_err;
    logic       irq_ack;

    int checks   = 0;
    int failures = 0;

    cpu_seq #(.IW(8), .TIMEOUT(c_TO)) u_dut (
        .clk           (clk),
        .reset_cycle_n (reset_cycle_n),
        .instruction   (instruction),
        .ram_ready     (ram_ready),
        .irq           (irq),
        .state         (state),
        .cycle         (cycle),
        .opcode        (opcode),
        .halted        (halted),
        .timeout_err   (timeout_err),
        .irq_ack       (irq_ack)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: queue of upcoming steps ----------------
    logic [7:0] m_state, m_opcode, m_inst;
    int         m_cycle, m_wait;
    bit         m_tout, m_irqseq;
    logic [7:0] m_q[$];

    function automatic logic [7:0] ref_decode(input logic [7:0] b);
        int hi, mid, lo;
        hi  = int'(b) / 64;
        mid = (int'(b) / 8) % 8;
        lo  = int'(b) % 8;
        if (b <= 8'h06)                       return b;
        if (hi == 0 && mid >= 2 && mid <= 5)  return 8'(mid * 8);
        if (hi == 1 && lo == 0)               return 8'h40;
        if (hi == 2)                          return 8'h80;
        return 8'h00;
    endfunction

    task automatic push_seq(input logic [7:0] op);
        case (op)
            8'h05: m_q = '{8'h03};
            8'h18: m_q = '{8'h19, 8'h04};
            8'h10: m_q = '{8'h19, 8'h15};
            8'h80: m_q = '{8'h09, 8'h0A};
            8'h40: m_q = '{8'h07, 8'h17};
            8'h06: m_q = '{8'h07};
            8'h03: m_q = '{8'h19, 8'h11, 8'h05};
            8'h04: m_q = '{8'h19, 8'h11, 8'h12};
            8'h20: m_q = '{8'h0C, 8'h13};
            8'h28: m_q = '{8'h10, 8'h0C, 8'h14};
            8'h02: m_q = '{8'h10, 8'h0C, 8'h0F};
            8'h01: m_q = '{8'h19, 8'h0C, 8'h0D, 8'h0E};
            default: m_q.delete();
        endcase
    endtask

    task automatic model_step(input logic rst_n, input logic [7:0] ins,
                              input logic rdy, input logic irq_in);
        logic [7:0] nxt;
        if (!rst_n) begin
            m_state = 8'h01; m_cycle = 0; m_opcode = 8'h00; m_inst = 8'h00;
            m_tout = 1'b0; m_wait = 0; m_irqseq = 1'b0; m_q.delete();
            return;
        end
        nxt = m_state;
        if (m_state == 8'h03) begin
            if (c_IRQ_ON && irq_in && !m_tout) begin
                nxt = 8'h1A; m_q = '{8'h0C, 8'h0D, 8'h0E}; m_irqseq = 1'b1;
            end
        end else if ((m_state == 8'h16 || m_state == 8'h19) && !rdy) begin
            m_wait++;
            if (m_wait >= c_TO) begin
                nxt = 8'h03; m_tout = 1'b1; m_wait = 0; m_q.delete();
            end
        end else begin
            m_wait = 0;
            if (m_state == 8'h01) m_q = '{8'h16, 8'h02, 8'h18};
            if (m_state == 8'h02) m_inst = ins;
            if (m_state == 8'h18) begin
                m_opcode = ref_decode(m_inst);
                push_seq(m_opcode);
            end
            if (m_q.size() > 0) begin
                nxt = m_q.pop_front();
            end else if (m_irqseq) begin
                nxt = 8'h01; m_irqseq = 1'b0;
            end else if (c_IRQ_ON && irq_in) begin
                nxt = 8'h1A; m_q = '{8'h0C, 8'h0D, 8'h0E}; m_irqseq = 1'b1;
            end else begin
                nxt = 8'h01;
            end
        end
        m_cycle = (nxt == 8'h01 || nxt == 8'h1A) ? 0 : ((m_cycle < 15) ? m_cycle + 1 : 15);
        m_state = nxt;
    endtask

    // ---------------- drive / check helpers ----------------
    task automatic tick(input logic rst_n, input logic [7:0] ins,
                        input logic rdy, input logic irq_in);
        reset_cycle_n = rst_n;
        instruction   = ins;
        ram_ready     = rdy;
        irq           = irq_in;
        @(posedge clk);
        #1;
        model_step(rst_n, ins, rdy, irq_in);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_st, input int e_cy,
                             input logic [7:0] e_op, input bit e_ht, input bit e_to,
                             input bit e_ack);
        chk({tag, ".state"},       int'(state),       int'(e_st));
        chk({tag, ".cycle"},       int'(cycle),       e_cy);
        chk({tag, ".opcode"},      int'(opcode),      int'(e_op));
        chk({tag, ".halted"},      int'(halted),      int'(e_ht));
        chk({tag, ".timeout_err"}, int'(timeout_err), int'(e_to));
        chk({tag, ".irq_ack"},     int'(irq_ack),     int'(e_ack));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic [7:0] ins;
        logic       rdy;
        logic       irq;
        logic [7:0] st;
        int         cy;
        logic [7:0] op;
        bit         ht;
        bit         to;
        bit         ack;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic [7:0] ins, input logic rdy,
                       input logic irq_in, input logic [7:0] st, input int cy,
                       input logic [7:0] op, input bit ht, input bit to, input bit ack);
        vec_t v;
        v.rst_n = rst_n; v.ins = ins; v.rdy = rdy; v.irq = irq_in;
        v.st = st; v.cy = cy; v.op = op; v.ht = ht; v.to = to; v.ack = ack;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] pool [20];
        logic [7:0] rins;
        logic       rrst, rrdy, rirq;

        // JMP, ready always high
        add(0, 8'h18, 1, 0, 8'h01, 0, 8'h00, 0, 0, 0);
        add(1, 8'h18, 1, 0, 8'h16, 1, 8'h00, 0, 0, 0);
        add(1, 8'h18, 1, 0, 8'h02, 2, 8'h00, 0, 0, 0);
        add(1, 8'h18, 1, 0, 8'h18, 3, 8'h00, 0, 0, 0);
        add(1, 8'h18, 1, 0, 8'h19, 4, 8'h18, 0, 0, 0);
        add(1, 8'h18, 1, 0, 8'h04, 5, 8'h18, 0, 0, 0);
        add(1, 8'h18, 1, 0, 8'h01, 0, 8'h18, 0, 0, 0);
        // CALL with three stalled WAIT_RAM cycles
        add(0, 8'h01, 0, 0, 8'h01, 0, 8'h00, 0, 0, 0);
        add(1, 8'h01, 0, 0, 8'h16, 1, 8'h00, 0, 0, 0);
        add(1, 8'h01, 0, 0, 8'h16, 2, 8'h00, 0, 0, 0);
        add(1, 8'h01, 0, 0, 8'h16, 3, 8'h00, 0, 0, 0);
        add(1, 8'h01, 0, 0, 8'h16, 4, 8'h00, 0, 0, 0);
        add(1, 8'h01, 1, 0, 8'h02, 5, 8'h00, 0, 0, 0);
        add(1, 8'h01, 1, 0, 8'h18, 6, 8'h00, 0, 0, 0);
        add(1, 8'h01, 1, 0, 8'h19, 7, 8'h01, 0, 0, 0);
        add(1, 8'h01, 1, 0, 8'h0C, 8, 8'h01, 0, 0, 0);
        add(1, 8'h01, 1, 0, 8'h0D, 9, 8'h01, 0, 0, 0);
        add(1, 8'h01, 1, 0, 8'h0E, 10, 8'h01, 0, 0, 0);
        add(1, 8'h01, 1, 0, 8'h01, 0, 8'h01, 0, 0, 0);
        // RAM timeout in WAIT_RAM, irq ignored in faulted HALT, reset clears
        add(0, 8'h00, 0, 1, 8'h01, 0, 8'h00, 0, 0, 0);
        add(1, 8'h00, 0, 1, 8'h16, 1, 8'h00, 0, 0, 0);
        add(1, 8'h00, 0, 1, 8'h16, 2, 8'h00, 0, 0, 0);
        add(1, 8'h00, 0, 1, 8'h16, 3, 8'h00, 0, 0, 0);
        add(1, 8'h00, 0, 1, 8'h16, 4, 8'h00, 0, 0, 0);
        add(1, 8'h00, 0, 1, 8'h03, 5, 8'h00, 1, 1, 0);
        add(1, 8'h00, 0, 1, 8'h03, 6, 8'h00, 1, 1, 0);
        add(1, 8'h00, 1, 1, 8'h03, 7, 8'h00, 1, 1, 0);
        add(0, 8'h00, 0, 0, 8'h01, 0, 8'h00, 0, 0, 0);
        // ALU with irq raised during ALU_WRITEBACK
        add(0, 8'h40, 1, 0, 8'h01, 0, 8'h00, 0, 0, 0);
        add(1, 8'h40, 1, 0, 8'h16, 1, 8'h00, 0, 0, 0);
        add(1, 8'h40, 1, 0, 8'h02, 2, 8'h00, 0, 0, 0);
        add(1, 8'h40, 1, 0, 8'h18, 3, 8'h00, 0, 0, 0);
        add(1, 8'h40, 1, 0, 8'h07, 4, 8'h40, 0, 0, 0);
        add(1, 8'h40, 1, 0, 8'h17, 5, 8'h40, 0, 0, 0);
`ifdef CPU_SEQ_IRQ_EN
        add(1, 8'h40, 1, 1, 8'h1A, 0, 8'h40, 0, 0, 1);
        add(1, 8'h40, 1, 0, 8'h0C, 1, 8'h40, 0, 0, 0);
        add(1, 8'h40, 1, 0, 8'h0D, 2, 8'h40, 0, 0, 0);
        add(1, 8'h40, 1, 0, 8'h0E, 3, 8'h40, 0, 0, 0);
        add(1, 8'h40, 1, 0, 8'h01, 0, 8'h40, 0, 0, 0);
`else
        add(1, 8'h40, 1, 1, 8'h01, 0, 8'h40, 0, 0, 0);
        add(1, 8'h40, 1, 1, 8'h16, 1, 8'h40, 0, 0, 0);
`endif
        // reset asserted in MOV_FETCH
        add(0, 8'h83, 1, 0, 8'h01, 0, 8'h00, 0, 0, 0);
        add(1, 8'h83, 1, 0, 8'h16, 1, 8'h00, 0, 0, 0);
        add(1, 8'h83, 1, 0, 8'h02, 2, 8'h00, 0, 0, 0);
        add(1, 8'h83, 1, 0, 8'h18, 3, 8'h00, 0, 0, 0);
        add(1, 8'hC3, 1, 0, 8'h09, 4, 8'h80, 0, 0, 0);
        add(0, 8'hC3, 1, 0, 8'h01, 0, 8'h00, 0, 0, 0);
        add(1, 8'hC3, 1, 0, 8'h16, 1, 8'h00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst_n, vecs[i].ins, vecs[i].rdy, vecs[i].irq);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cy, vecs[i].op,
                      vecs[i].ht, vecs[i].to, vecs[i].ack);
        end

        // HLT: sticky for 20 cycles, cycle saturates, reset leaves
        tick(0, 8'h05, 1, 0); check_all("hlt_rst", 8'h01, 0, 8'h00, 0, 0, 0);
        tick(1, 8'h05, 1, 0); tick(1, 8'h05, 1, 0); tick(1, 8'h05, 1, 0);
        tick(1, 8'h05, 1, 0); check_all("hlt_enter", 8'h03, 4, 8'h05, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick(1, 8'h00, 1, 0);
            check_all($sformatf("hlt_hold%0d", k), 8'h03, (4 + k > 15) ? 15 : 4 + k,
                      8'h05, 1, 0, 0);
        end
        tick(0, 8'h00, 1, 0); check_all("hlt_exit", 8'h01, 0, 8'h00, 0, 0, 0);

        // ready arriving on the cycle the counter would expire wins
        tick(1, 8'h00, 0, 0);
        for (int k = 0; k < 3; k++) tick(1, 8'h00, 0, 0);
        check_all("edge_wait", 8'h16, 4, 8'h00, 0, 0, 0);
        tick(1, 8'h00, 1, 0); check_all("edge_ready", 8'h02, 5, 8'h00, 0, 0, 0);

        // timeout inside OPERAND
        tick(0, 8'h18, 1, 0);
        for (int k = 0; k < 4; k++) tick(1, 8'h18, 1, 0);
        check_all("opnd_enter", 8'h19, 4, 8'h18, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick(1, 8'h18, 0, 0);
        check_all("opnd_wait", 8'h19, 7, 8'h18, 0, 0, 0);
        tick(1, 8'h18, 0, 0); check_all("opnd_tout", 8'h03, 8, 8'h18, 1, 1, 0);
        tick(1, 8'h18, 0, 1); check_all("opnd_irq_ign", 8'h03, 9, 8'h18, 1, 1, 0);

        // randomized run against the reference model
        pool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h13, 8'h1B, 8'h22,
                 8'h2F, 8'h45, 8'h40, 8'h83, 8'hBF, 8'hC3, 8'h07, 8'h0A, 8'h68, 8'hFF};
        tick(0, 8'h00, 1, 0);
        for (int n = 0; n < 3000; n++) begin
            rrst = ($urandom_range(0, 59) != 0);
            rins = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
            rrdy = ($urandom_range(0, 9) < 7);
            rirq = ($urandom_range(0, 7) == 0);
            tick(rrst, rins, rrdy, rirq);
            check_all($sformatf("rnd%0d", n), m_state, m_cycle, m_opcode,
                      (m_state == 8'h03), m_tout, c_IRQ_ON && (m_state == 8'h1A));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
